// File: rtl/trap_pkg.sv
// rtl/trap_pkg.sv - shared types and constants for the machine-mode trap sequencer
package trap_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    JUMP
  } trap_state_t;

  typedef enum logic [1:0] {
    NONE,
    EXC,
    MRET,
    IRQ
  } trap_kind_t;

  localparam logic [3:0] IRQ_M_SOFT  = 4'd3;
  localparam logic [3:0] IRQ_M_TIMER = 4'd7;
  localparam logic [3:0] IRQ_M_EXT   = 4'd11;

  localparam logic [1:0] MTVEC_MODE_DIRECT   = 2'd0;
  localparam logic [1:0] MTVEC_MODE_VECTORED = 2'd1;

endpackage

// File: rtl/trap_irq_arb.sv
// rtl/trap_irq_arb.sv - combinational machine interrupt arbiter (external > software > timer)
module trap_irq_arb
  import trap_pkg::*;
(
  input  logic       mstatus_ie_i,
  input  logic       mie_external_i,
  input  logic       mie_timer_i,
  input  logic       mie_sw_i,
  input  logic       mip_external_i,
  input  logic       mip_timer_i,
  input  logic       mip_sw_i,
  output logic       irq_valid,
  output logic [3:0] irq_cause
);

  logic ext_pend;
  logic sw_pend;
  logic tmr_pend;

  assign ext_pend = mstatus_ie_i & mie_external_i & mip_external_i;
  assign sw_pend  = mstatus_ie_i & mie_sw_i & mip_sw_i;
  assign tmr_pend = mstatus_ie_i & mie_timer_i & mip_timer_i;

  always_comb begin
    irq_valid = 1'b0;
    irq_cause = 4'd0;
    if (ext_pend) begin
      irq_valid = 1'b1;
      irq_cause = IRQ_M_EXT;
    end else if (sw_pend) begin
      irq_valid = 1'b1;
      irq_cause = IRQ_M_SOFT;
    end else if (tmr_pend) begin
      irq_valid = 1'b1;
      irq_cause = IRQ_M_TIMER;
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// rtl/trap_ctrl.sv - trap sequencer: arbitrates exceptions, mret and interrupts, strobes CSRs, redirects fetch
module trap_ctrl
  import trap_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            commit_valid_i,
  input  logic [XLEN-1:0] commit_pc_i,
  input  logic [XLEN-1:0] commit_npc_i,
  input  logic            exc_valid_i,
  input  logic [3:0]      exc_code_i,
  input  logic [XLEN-1:0] exc_tval_i,
  input  logic            mret_i,
  input  logic            mstatus_ie_i,
  input  logic            mie_external_i,
  input  logic            mie_timer_i,
  input  logic            mie_sw_i,
  input  logic            mip_external_i,
  input  logic            mip_timer_i,
  input  logic            mip_sw_i,
  input  logic [XLEN-1:0] mtvec_i,
  input  logic [XLEN-1:0] epc_i,
  output logic            ie_type_o,
  output logic            set_cause_o,
  output logic [3:0]      trap_cause_o,
  output logic            set_epc_o,
  output logic [XLEN-1:0] epc_o,
  output logic            set_mtval_o,
  output logic [XLEN-1:0] mtval_o,
  output logic            mstatus_ie_clear_o,
  output logic            mstatus_ie_set_o,
  output logic            flush_o,
  output logic            stall_o,
  output logic            redirect_valid_o,
  output logic [XLEN-1:0] redirect_pc_o,
  input  logic            redirect_ready_i
);

  trap_state_t     state_q, state_d;
  trap_kind_t      kind_q, ev_kind;
  logic [3:0]      cause_q;
  logic [XLEN-1:0] epc_q;
  logic [XLEN-1:0] tval_q;
  logic            ie_type_q;

  logic            irq_valid;
  logic [3:0]      irq_cause;
  logic [XLEN-1:0] vec_base;
  logic [XLEN-1:0] trap_target;

  trap_irq_arb u_irq_arb (
    .mstatus_ie_i   (mstatus_ie_i),
    .mie_external_i (mie_external_i),
    .mie_timer_i    (mie_timer_i),
    .mie_sw_i       (mie_sw_i),
    .mip_external_i (mip_external_i),
    .mip_timer_i    (mip_timer_i),
    .mip_sw_i       (mip_sw_i),
    .irq_valid      (irq_valid),
    .irq_cause      (irq_cause)
  );

  always_comb begin
    ev_kind = NONE;
    if (exc_valid_i)    ev_kind = EXC;
    else if (mret_i)    ev_kind = MRET;
    else if (irq_valid) ev_kind = IRQ;
  end

  // mret keeps the previous cause/epc/tval so the CSR-facing data outputs do not glitch
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      kind_q    <= NONE;
      cause_q   <= 4'd0;
      epc_q     <= '0;
      tval_q    <= '0;
      ie_type_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && commit_valid_i && ev_kind != NONE) begin
        kind_q <= ev_kind;
        if (ev_kind == EXC) begin
          cause_q   <= exc_code_i;
          epc_q     <= commit_pc_i;
          tval_q    <= exc_tval_i;
          ie_type_q <= 1'b0;
        end else if (ev_kind == IRQ) begin
          cause_q   <= irq_cause;
          epc_q     <= commit_npc_i;
          tval_q    <= '0;
          ie_type_q <= 1'b1;
        end
      end
    end
  end

  assign vec_base = {mtvec_i[XLEN-1:2], 2'b00};

  always_comb begin
    trap_target = vec_base;
    if (mtvec_i[1:0] == MTVEC_MODE_VECTORED && ie_type_q)
      trap_target = vec_base + XLEN'({cause_q, 2'b00});
  end

  always_comb begin
    state_d            = state_q;
    set_cause_o        = 1'b0;
    set_epc_o          = 1'b0;
    set_mtval_o        = 1'b0;
    mstatus_ie_clear_o = 1'b0;
    mstatus_ie_set_o   = 1'b0;
    flush_o            = 1'b0;
    redirect_valid_o   = 1'b0;
    redirect_pc_o      = '0;
    case (state_q)
      IDLE: begin
        if (commit_valid_i && ev_kind != NONE) state_d = WRITE;
      end
      WRITE: begin
        flush_o = 1'b1;
        if (kind_q == MRET) begin
          mstatus_ie_set_o = 1'b1;
        end else begin
          set_cause_o        = 1'b1;
          set_epc_o          = 1'b1;
          set_mtval_o        = 1'b1;
          mstatus_ie_clear_o = 1'b1;
        end
        state_d = JUMP;
      end
      JUMP: begin
        redirect_valid_o = 1'b1;
        redirect_pc_o    = (kind_q == MRET) ? epc_i : trap_target;
        if (redirect_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign stall_o      = (state_q != IDLE);
  assign ie_type_o    = ie_type_q;
  assign trap_cause_o = cause_q;
  assign epc_o        = epc_q;
  assign mtval_o      = tval_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// tb/tb_trap_ctrl.sv - directed self-checking bench for trap_ctrl
module tb_trap_ctrl;

  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic            commit_valid_i;
  logic [XLEN-1:0] commit_pc_i;
  logic [XLEN-1:0] commit_npc_i;
  logic            exc_valid_i;
  logic [3:0]      exc_code_i;
  logic [XLEN-1:0] exc_tval_i;
  logic            mret_i;
  logic            mstatus_ie_i;
  logic            mie_external_i, mie_timer_i, mie_sw_i;
  logic            mip_external_i, mip_timer_i, mip_sw_i;
  logic [XLEN-1:0] mtvec_i;
  logic [XLEN-1:0] epc_i;
  logic            ie_type_o;
  logic            set_cause_o;
  logic [3:0]      trap_cause_o;
  logic            set_epc_o;
  logic [XLEN-1:0] epc_o;
  logic            set_mtval_o;
  logic [XLEN-1:0] mtval_o;
  logic            mstatus_ie_clear_o;
  logic            mstatus_ie_set_o;
  logic            flush_o;
  logic            stall_o;
  logic            redirect_valid_o;
  logic [XLEN-1:0] redirect_pc_o;
  logic            redirect_ready_i;

  int checks   = 0;
  int failures = 0;

  logic [7:0] strobes;
  assign strobes = {set_cause_o, set_epc_o, set_mtval_o, mstatus_ie_clear_o,
                    mstatus_ie_set_o, flush_o, stall_o, redirect_valid_o};

  localparam logic [7:0] S_IDLE  = 8'b0000_0000;
  localparam logic [7:0] S_TRAPW = 8'b1111_0110;
  localparam logic [7:0] S_MRETW = 8'b0000_1110;
  localparam logic [7:0] S_JUMP  = 8'b0000_0011;

  trap_ctrl #(.XLEN(XLEN)) dut (
    .clk                (clk),
    .rst                (rst),
    .commit_valid_i     (commit_valid_i),
    .commit_pc_i        (commit_pc_i),
    .commit_npc_i       (commit_npc_i),
    .exc_valid_i        (exc_valid_i),
    .exc_code_i         (exc_code_i),
    .exc_tval_i         (exc_tval_i),
    .mret_i             (mret_i),
    .mstatus_ie_i       (mstatus_ie_i),
    .mie_external_i     (mie_external_i),
    .mie_timer_i        (mie_timer_i),
    .mie_sw_i           (mie_sw_i),
    .mip_external_i     (mip_external_i),
    .mip_timer_i        (mip_timer_i),
    .mip_sw_i           (mip_sw_i),
    .mtvec_i            (mtvec_i),
    .epc_i              (epc_i),
    .ie_type_o          (ie_type_o),
    .set_cause_o        (set_cause_o),
    .trap_cause_o       (trap_cause_o),
    .set_epc_o          (set_epc_o),
    .epc_o              (epc_o),
    .set_mtval_o        (set_mtval_o),
    .mtval_o            (mtval_o),
    .mstatus_ie_clear_o (mstatus_ie_clear_o),
    .mstatus_ie_set_o   (mstatus_ie_set_o),
    .flush_o            (flush_o),
    .stall_o            (stall_o),
    .redirect_valid_o   (redirect_valid_o),
    .redirect_pc_o      (redirect_pc_o),
    .redirect_ready_i   (redirect_ready_i)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic commit(input logic [XLEN-1:0] pc, input logic [XLEN-1:0] npc,
                        input logic exc, input logic [3:0] code,
                        input logic [XLEN-1:0] tval, input logic mret);
    commit_valid_i = 1'b1;
    commit_pc_i    = pc;
    commit_npc_i   = npc;
    exc_valid_i    = exc;
    exc_code_i     = code;
    exc_tval_i     = tval;
    mret_i         = mret;
  endtask

  task automatic idle_commit();
    commit_valid_i = 1'b0;
    exc_valid_i    = 1'b0;
    mret_i         = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    commit_valid_i = 0; commit_pc_i = 0; commit_npc_i = 0;
    exc_valid_i = 0; exc_code_i = 0; exc_tval_i = 0; mret_i = 0;
    mstatus_ie_i = 0;
    mie_external_i = 0; mie_timer_i = 0; mie_sw_i = 0;
    mip_external_i = 0; mip_timer_i = 0; mip_sw_i = 0;
    mtvec_i = 0; epc_i = 0; redirect_ready_i = 1'b1;
    tick(); tick();
    chk("reset_strobes", XLEN'(strobes), XLEN'(S_IDLE));
    chk("reset_epc", epc_o, 0);
    chk("reset_cause", XLEN'({ie_type_o, trap_cause_o}), 0);
    rst = 1'b0;
    tick();

    // illegal instruction
    mtvec_i = 64'h8000_0100;
    commit(64'h8000_0010, 64'h8000_0014, 1'b1, 4'd2, 64'hDEAD, 1'b0);
    tick(); idle_commit();
    chk("ill_write_strobes", XLEN'(strobes), XLEN'(S_TRAPW));
    chk("ill_epc", epc_o, 64'h8000_0010);
    chk("ill_cause", XLEN'(trap_cause_o), 2);
    chk("ill_ie_type", XLEN'(ie_type_o), 0);
    chk("ill_mtval", mtval_o, 64'hDEAD);
    tick();
    chk("ill_jump_strobes", XLEN'(strobes), XLEN'(S_JUMP));
    chk("ill_redirect", redirect_pc_o, 64'h8000_0100);
    tick();
    chk("ill_back_idle", XLEN'(strobes), XLEN'(S_IDLE));

    // vectored timer interrupt; pending drops after latch
    mtvec_i = 64'h8000_0101;
    mstatus_ie_i = 1; mie_timer_i = 1; mip_timer_i = 1;
    commit(64'h8000_0020, 64'h8000_0024, 1'b0, 4'd0, 64'h55, 1'b0);
    tick(); idle_commit(); mip_timer_i = 0;
    chk("tmr_write_strobes", XLEN'(strobes), XLEN'(S_TRAPW));
    chk("tmr_epc", epc_o, 64'h8000_0024);
    chk("tmr_cause", XLEN'(trap_cause_o), 7);
    chk("tmr_ie_type", XLEN'(ie_type_o), 1);
    chk("tmr_mtval", mtval_o, 0);
    tick();
    chk("tmr_redirect", redirect_pc_o, 64'h8000_011C);
    chk("tmr_jump_strobes", XLEN'(strobes), XLEN'(S_JUMP));
    tick();
    chk("tmr_back_idle", XLEN'(strobes), XLEN'(S_IDLE));

    // mret
    epc_i = 64'h8000_0200;
    commit(64'h8000_0030, 64'h8000_0034, 1'b0, 4'd0, 0, 1'b1);
    tick(); idle_commit();
    chk("mret_write_strobes", XLEN'(strobes), XLEN'(S_MRETW));
    tick();
    chk("mret_jump_strobes", XLEN'(strobes), XLEN'(S_JUMP));
    chk("mret_redirect", redirect_pc_o, 64'h8000_0200);
    tick();
    chk("mret_back_idle", XLEN'(strobes), XLEN'(S_IDLE));

    // exception wins over pending external+timer, external taken afterwards
    mie_external_i = 1; mip_external_i = 1; mip_timer_i = 1;
    commit(64'h8000_0040, 64'h8000_0044, 1'b1, 4'd5, 64'h1234, 1'b1);
    tick(); idle_commit();
    chk("pri_exc_cause", XLEN'(trap_cause_o), 5);
    chk("pri_exc_ie_type", XLEN'(ie_type_o), 0);
    chk("pri_exc_epc", epc_o, 64'h8000_0040);
    tick();
    chk("pri_exc_redirect", redirect_pc_o, 64'h8000_0100);
    tick();
    commit(64'h8000_0044, 64'h8000_0048, 1'b0, 4'd0, 0, 1'b0);
    tick(); idle_commit();
    chk("pri_irq_strobes", XLEN'(strobes), XLEN'(S_TRAPW));
    chk("pri_irq_cause", XLEN'(trap_cause_o), 11);
    chk("pri_irq_epc", epc_o, 64'h8000_0048);
    tick();
    chk("pri_irq_redirect", redirect_pc_o, 64'h8000_012C);
    tick();
    mstatus_ie_i = 0; mie_external_i = 0; mip_external_i = 0;
    mie_timer_i = 0; mip_timer_i = 0;

    // redirect back-pressure with ignored commits
    mtvec_i = 64'h8000_0200;
    redirect_ready_i = 0;
    commit(64'h8000_0080, 64'h8000_0084, 1'b1, 4'd1, 64'h80, 1'b0);
    tick(); idle_commit();
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_strobes", XLEN'(strobes), XLEN'(S_JUMP));
      chk("bp_redirect", redirect_pc_o, 64'h8000_0200);
      commit(64'h9000_0000 + XLEN'(i), 64'h9000_0100, 1'b1, 4'd4, 64'h99, 1'b0);
      tick();
    end
    idle_commit();
    chk("bp_still_jump", XLEN'(strobes), XLEN'(S_JUMP));
    redirect_ready_i = 1;
    tick();
    chk("bp_back_idle", XLEN'(strobes), XLEN'(S_IDLE));
    chk("bp_epc_kept", epc_o, 64'h8000_0080);
    chk("bp_cause_kept", XLEN'(trap_cause_o), 1);
    tick();
    chk("bp_no_extra_trap", XLEN'(strobes), XLEN'(S_IDLE));

    // reset during WRITE
    commit(64'h8000_00A0, 64'h8000_00A4, 1'b1, 4'd6, 64'h77, 1'b0);
    tick(); idle_commit();
    chk("rst_pre_write", XLEN'(strobes), XLEN'(S_TRAPW));
    rst = 1;
    tick();
    chk("rst_strobes", XLEN'(strobes), XLEN'(S_IDLE));
    chk("rst_epc", epc_o, 0);
    chk("rst_mtval", mtval_o, 0);
    chk("rst_redirect_pc", redirect_pc_o, 0);
    chk("rst_cause", XLEN'({ie_type_o, trap_cause_o}), 0);
    rst = 0;
    tick();
    chk("rst_stays_idle", XLEN'(strobes), XLEN'(S_IDLE));

    // global enable off: nothing taken
    mstatus_ie_i = 0;
    mie_external_i = 1; mie_timer_i = 1; mie_sw_i = 1;
    mip_external_i = 1; mip_timer_i = 1; mip_sw_i = 1;
    commit(64'h8000_00C0, 64'h8000_00C4, 1'b0, 4'd0, 0, 1'b0);
    tick();
    chk("mie_off_no_trap", XLEN'(strobes), XLEN'(S_IDLE));
    tick();
    idle_commit();
    chk("mie_off_no_trap2", XLEN'(strobes), XLEN'(S_IDLE));

    // software beats timer when enabled
    mstatus_ie_i = 1; mie_external_i = 0;
    commit(64'h8000_00D0, 64'h8000_00D4, 1'b0, 4'd0, 0, 1'b0);
    tick(); idle_commit();
    chk("sw_cause", XLEN'(trap_cause_o), 3);
    tick();
    chk("sw_redirect", redirect_pc_o, 64'h8000_0200);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
# trap_ctrl

Trap sequencer between the commit stage and the machine-mode CSR file. It arbitrates synchronous exceptions, `mret` and pending interrupts at instruction boundaries, then drives the CSR file's update strobes (cause, epc, mtval, mstatus IE stack). It finishes by flushing the pipeline and issuing a PC redirect to the trap vector or the saved epc. While a trap is in progress it stalls further commits.

## Interface
Parameters:
- `XLEN`, 64, data/address width.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `commit_valid_i` in 1: one instruction commits this cycle.
- `commit_pc_i` in XLEN: PC of the committing instruction.
- `commit_npc_i` in XLEN: PC of the next sequential/target instruction.
- `exc_valid_i` in 1: the committing instruction raised an exception.
- `exc_code_i` in 4: exception code.
- `exc_tval_i` in XLEN: faulting address or instruction.
- `mret_i` in 1: the committing instruction is `mret`.
- `mstatus_ie_i` in 1: global machine interrupt enable, from the CSR file.
- `mie_external_i`, `mie_timer_i`, `mie_sw_i` in 1 each: per-source interrupt enables.
- `mip_external_i`, `mip_timer_i`, `mip_sw_i` in 1 each: per-source interrupt pending bits.
- `mtvec_i` in XLEN: trap vector base and mode.
- `epc_i` in XLEN: current mepc.
- `ie_type_o` out 1: 1 = interrupt, 0 = exception.
- `set_cause_o` out 1: mcause write strobe.
- `trap_cause_o` out 4: cause code.
- `set_epc_o` out 1: mepc write strobe.
- `epc_o` out XLEN: value written to mepc.
- `set_mtval_o` out 1: mtval write strobe.
- `mtval_o` out XLEN: value written to mtval.
- `mstatus_ie_clear_o` out 1: push the IE stack (trap entry).
- `mstatus_ie_set_o` out 1: pop the IE stack (`mret`).
- `flush_o` out 1: kill all younger instructions in the pipeline.
- `stall_o` out 1: block commits while the sequencer is busy.
- `redirect_valid_o` out 1: new fetch PC is valid.
- `redirect_pc_o` out XLEN: new fetch PC.
- `redirect_ready_i` in 1: fetch has accepted the redirect.

## Operation
- FSM states: IDLE, WRITE, JUMP.
- Event detection happens only in IDLE with `commit_valid_i`=1. Priority order: exception > mret > interrupt.
- Interrupt pending conditions:
  - External: `mstatus_ie_i & mie_external_i & mip_external_i`, cause 11.
  - Software: the same form on the sw bits, cause 3.
  - Timer: the same form on the timer bits, cause 7.
- Interrupt source priority when several are pending: external > software > timer.
- On an event, latch the kind, cause, epc and tval, then go to WRITE. Latched values:
  - Exception: epc = `commit_pc_i`; tval = `exc_tval_i`; cause = `exc_code_i`; ie_type = 0.
  - Interrupt: the committing instruction retires normally; epc = `commit_npc_i`; tval = 0; ie_type = 1.
  - mret: nothing latched except the kind.
- WRITE lasts exactly one cycle and asserts `flush_o`.
  - Trap: also asserts `set_cause_o`, `set_epc_o`, `set_mtval_o` and `mstatus_ie_clear_o`.
  - mret: also asserts `mstatus_ie_set_o` only.
  - Next state: JUMP.
- JUMP computes the redirect target:
  - Trap with `mtvec_i[1:0]`=01 (vectored) and ie_type=1: `{mtvec_i[XLEN-1:2],2'b00} + (cause << 2)`, computed modulo 2^XLEN.
  - Any other trap: `{mtvec_i[XLEN-1:2],2'b00}`.
  - mret: `epc_i`, sampled in JUMP, which is after the CSR update.
- JUMP holds `redirect_valid_o`=1 and a stable `redirect_pc_o` until `redirect_ready_i`=1. It moves to IDLE in the cycle after that handshake.
- `stall_o` = 1 whenever the state is not IDLE. Any `commit_valid_i` received in WRITE or JUMP is ignored.
- Reset values: state IDLE; all strobes, `flush_o`, `stall_o` and `redirect_valid_o` are 0; all data outputs are 0.

## Timing
- Event commit in cycle N produces:
  - Cycle N+1: CSR strobes and `flush_o`.
  - Cycle N+2: `redirect_valid_o`.
  - Minimum total latency is 3 cycles back to IDLE when ready is already high.
- All outputs are registered or decoded from state and latched values only. There is no combinational path from `commit_*` to any output.
- Strobes are single-cycle pulses and never repeat for one event.
- `rst` in any state returns to IDLE on the next edge with no strobes. A redirect in progress is abandoned.
- When `exc_valid_i`, `mret_i` and an interrupt occur together, only the exception is taken. The interrupt remains pending and is taken at a later commit.
- Interrupt pending bits that drop while in WRITE or JUMP do not alter the trap already latched.

## Structure
- Package `trap_pkg` contains:
  - State enum `trap_state_t`.
  - Cause constants `IRQ_M_SOFT`=3, `IRQ_M_TIMER`=7, `IRQ_M_EXT`=11.
  - `MTVEC_MODE_DIRECT`=0 and `MTVEC_MODE_VECTORED`=1.
  - Event-kind enum: NONE, EXC, MRET, IRQ.
- Sub-module `trap_irq_arb` (combinational): takes the six enable/pending bits and `mstatus_ie_i`, and outputs `irq_valid` and `irq_cause[3:0]`.

## Test plan
- Illegal instruction: exc_code=2, pc=0x8000_0010, tval=0xDEAD, mtvec=0x8000_0100.
  - N+1: set_cause/set_epc/set_mtval/ie_clear pulse with epc_o=0x8000_0010, cause=2, ie_type=0.
  - N+2: redirect to 0x8000_0100.
- Timer interrupt, vectored mtvec=0x8000_0101, npc=0x8000_0024: epc_o=0x8000_0024, cause=7, ie_type=1, mtval_o=0, redirect=0x8000_011C.
- mret with epc_i=0x8000_0200: a single mstatus_ie_set_o pulse, no cause/epc strobes, redirect=0x8000_0200.
- External and timer both pending plus an exception on the same commit: exception taken. At the next commit after IDLE, cause 11 is taken.
- redirect_ready_i held low for 5 cycles: valid and pc stable, stall_o=1, commits ignored, and IDLE follows the handshake.
- rst asserted during WRITE: the next cycle has all outputs 0 and the state in IDLE. mstatus_ie_i=0 with all pending bits set: no trap is taken.
